// File: rtl/elastic_pipeliner_pipe_slice.sv
// Register slice with a skid entry: a two-deep elastic buffer on one valid/ready link.
// Latency: one cycle from an s_* handshake to m_valid.
// Backpressure: s_ready is a flop (skid empty next cycle), so m_ready never reaches s_ready combinationally.
module pipe_slice #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             s_valid,
    input  logic [WIDTH-1:0] s_data,
    output logic             s_ready,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    input  logic             m_ready
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             push;
    logic             pop;
    logic             ld_main_in;
    logic             ld_main_skid;
    logic             ld_skid;

    assign push    = s_valid && s_ready;
    assign pop     = m_valid && m_ready;
    assign m_valid = (state_q != EMPTY);
    assign m_data  = main_q;

    // Next state and payload-load strobes; flush empties the slice and suppresses all loads.
    always_comb begin
        state_d      = state_q;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    state_d    = ONE;
                    ld_main_in = 1'b1;
                end
            end
            ONE: begin
                if (push && pop) begin
                    ld_main_in = 1'b1;
                end else if (push) begin
                    state_d = FULL;
                    ld_skid = 1'b1;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // s_ready is low here, so only a pop can happen.
                if (pop) begin
                    state_d      = ONE;
                    ld_main_skid = 1'b1;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
        if (flush) begin
            state_d      = EMPTY;
            ld_main_in   = 1'b0;
            ld_main_skid = 1'b0;
            ld_skid      = 1'b0;
        end
    end

    // Occupancy state register; asynchronous reset drops both entries at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Registered ready: held low in reset, then high unless the slice will be full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_ready <= 1'b0;
        end else begin
            s_ready <= (state_d != FULL);
        end
    end

    // Payload registers only move on a push or a skid-to-main shift, never on idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (ld_main_in) begin
                main_q <= s_data;
            end else if (ld_main_skid) begin
                main_q <= skid_q;
            end
            if (ld_skid) begin
                skid_q <= s_data;
            end
        end
    end

endmodule

// File: rtl/elastic_pipeliner.sv
// Chain of STAGES skid slices for retiming long routes, plus a word occupancy counter.
// Latency: STAGES cycles from input handshake to out_valid, one word per cycle sustained.
// Backpressure: absorbs 2*STAGES words; in_ready is registered and falls once slice 0 is full.
module elastic_pipeliner #(
    parameter  int WIDTH  = 8,
    parameter  int STAGES = 1,
    localparam int CNT_W  = $clog2(2 * STAGES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CNT_W-1:0] occupancy
);

    if (STAGES < 1) begin : g_bad_stages
        $error("elastic_pipeliner: STAGES must be at least 1");
    end

    // Link k sits between slice k-1 and slice k; link 0 is upstream, link STAGES downstream.
    logic             vld [STAGES+1];
    logic             rdy [STAGES+1];
    logic [WIDTH-1:0] dat [STAGES+1];
    logic             push;
    logic             pop;

    assign vld[0]      = in_valid;
    assign dat[0]      = in_data;
    assign in_ready    = rdy[0];
    assign out_valid   = vld[STAGES];
    assign out_data    = dat[STAGES];
    assign rdy[STAGES] = out_ready;

    for (genvar s = 0; s < STAGES; s++) begin : g_slice
        pipe_slice #(
            .WIDTH (WIDTH)
        ) u_slice (
            .clk     (clk),
            .rst_n   (rst_n),
            .flush   (flush),
            .s_valid (vld[s]),
            .s_data  (dat[s]),
            .s_ready (rdy[s]),
            .m_valid (vld[s+1]),
            .m_data  (dat[s+1]),
            .m_ready (rdy[s+1])
        );
    end

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // Word count across all slices; flush wins over any same-cycle handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occupancy <= '0;
        end else if (flush) begin
            occupancy <= '0;
        end else if (push && !pop) begin
            occupancy <= occupancy + CNT_W'(1);
        end else if (pop && !push) begin
            occupancy <= occupancy - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_elastic_pipeliner.sv
// Directed bench for elastic_pipeliner: a STAGES=3 instance for the main cases, a STAGES=1 instance for the corner.
// Inputs are driven 1ns after the rising edge and outputs sampled on the falling edge.
// Expected values are hand-derived or come from a small in-order scoreboard queue.
module tb_elastic_pipeliner;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;

    logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [7:0] a_in_data, a_out_data;
    logic [2:0] a_occ;

    logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [7:0] b_in_data, b_out_data;
    logic [1:0] b_occ;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    elastic_pipeliner #(.WIDTH(8), .STAGES(3)) u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (a_in_valid),
        .in_data   (a_in_data),
        .in_ready  (a_in_ready),
        .out_valid (a_out_valid),
        .out_data  (a_out_data),
        .out_ready (a_out_ready),
        .occupancy (a_occ)
    );

    elastic_pipeliner #(.WIDTH(8), .STAGES(1)) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (b_in_valid),
        .in_data   (b_in_data),
        .in_ready  (b_in_ready),
        .out_valid (b_out_valid),
        .out_data  (b_out_data),
        .out_ready (b_out_ready),
        .occupancy (b_occ)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Upstream protocol: a stalled word must keep its payload until accepted.
    logic       hv = 1'b0;
    logic       hr = 1'b0;
    logic [7:0] hd = '0;
    always @(negedge clk) begin
        if (hv && !hr && a_in_valid)
            assert (a_in_data == hd) else $error("FAIL upstream_hold: in_data changed while stalled");
        hv = a_in_valid;
        hr = a_in_ready;
        hd = a_in_data;
    end

    logic [7:0] sb  [$];
    logic [7:0] sb2 [$];

    initial begin
        int         acc, k, got, first_rdy, sent, recv, cyc, recv_win;
        logic       took, pop, push, prev_stall, prev_rdy, prev_pop;
        logic [7:0] prev_dat;
        logic [1:0] prev_occ;

        rst_n = 1'b1; flush = 1'b0;
        a_in_valid = 0; a_in_data = 0; a_out_ready = 0;
        b_in_valid = 0; b_in_data = 0; b_out_ready = 0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_in_ready", a_in_ready, 0);
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_occ", a_occ, 0);
        chk("rst_out_data", a_out_data, 0);
        chk("rst_b_in_ready", b_in_ready, 0);
        @(posedge clk); @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        chk("ready_after_rst", a_in_ready, 1);
        chk("ready_after_rst_b", b_in_ready, 1);

        // Streaming 0x01..0x10 with the consumer always ready.
        a_out_ready = 1;
        for (int i = 0; i < 20; i++) begin
            a_in_valid = (i < 16);
            a_in_data  = 8'(i + 1);
            mid();
            if (i < 16) chk("stream_in_ready", a_in_ready, 1);
            chk("stream_occ", a_occ, (i <= 16) ? ((i < 3) ? i : 3) : 19 - i);
            if (i >= 3 && i < 19) begin
                chk("stream_vld", a_out_valid, 1);
                chk("stream_dat", a_out_data, i - 2);
            end else begin
                chk("stream_vld", a_out_valid, 0);
            end
            tick();
        end

        // Fill against a stalled consumer: capacity is 2*STAGES words.
        a_in_valid = 0;
        a_out_ready = 0; a_in_valid = 1; a_in_data = 8'hA0; acc = 0;
        for (int i = 0; i < 10; i++) begin
            mid();
            took = a_in_ready;
            tick();
            if (took) begin
                acc++;
                a_in_data = a_in_data + 8'd1;
            end
        end
        chk("fill_accepts", acc, 6);
        chk("fill_ready", a_in_ready, 0);
        chk("fill_occ", a_occ, 6);
        chk("fill_head_vld", a_out_valid, 1);
        chk("fill_head_dat", a_out_data, 8'hA0);

        a_in_valid = 0; a_out_ready = 1; k = 0; first_rdy = -1;
        for (int i = 0; i < 8; i++) begin
            mid();
            if (a_in_ready && first_rdy < 0) first_rdy = i;
            if (a_out_valid) begin
                chk("drain_dat", a_out_data, 8'hA0 + k);
                k++;
            end
            tick();
        end
        chk("drain_count", k, 6);
        chk("drain_occ", a_occ, 0);
        chk("drain_ready_back", (first_rdy >= 1 && first_rdy <= 7), 1);

        // Flush with four words in flight and a push and pop in the same cycle.
        a_out_ready = 0; a_in_valid = 1;
        for (int i = 0; i < 4; i++) begin
            a_in_data = 8'(8'hB0 + i);
            tick();
        end
        a_in_data = 8'hEE; a_out_ready = 1; flush = 1;
        mid();
        chk("flush_pre_occ", a_occ, 4);
        chk("flush_pop_vld", a_out_valid, 1);
        chk("flush_pop_dat", a_out_data, 8'hB0);
        chk("flush_push_rdy", a_in_ready, 1);
        tick();
        flush = 0; a_in_valid = 0;
        chk("flush_vld", a_out_valid, 0);
        chk("flush_occ", a_occ, 0);
        chk("flush_rdy", a_in_ready, 1);
        got = 0;
        for (int i = 0; i < 6; i++) begin
            mid();
            if (a_out_valid) got++;
            tick();
        end
        chk("flush_no_leak", got, 0);

        // Asynchronous reset between edges while streaming.
        a_out_ready = 1; a_in_valid = 1;
        for (int i = 0; i < 3; i++) begin
            a_in_data = 8'(8'h60 + i);
            tick();
        end
        chk("arst_pre_vld", a_out_valid, 1);
        #2;
        rst_n = 0; a_in_data = 8'h5A;
        #1;
        chk("arst_vld", a_out_valid, 0);
        chk("arst_occ", a_occ, 0);
        chk("arst_rdy", a_in_ready, 0);
        #2 rst_n = 1;
        tick();
        chk("arst_rdy_edge", a_in_ready, 1);
        tick();
        a_in_valid = 0;
        mid(); chk("arst_r1_vld", a_out_valid, 0);
        tick();
        mid(); chk("arst_r2_vld", a_out_valid, 0);
        tick();
        mid();
        chk("arst_r3_vld", a_out_valid, 1);
        chk("arst_r3_dat", a_out_data, 8'h5A);
        tick();
        chk("arst_drained", a_occ, 0);

        // Random stalls on both sides against an in-order scoreboard.
        a_in_valid = 0; a_out_ready = 0;
        sent = 0; recv = 0; cyc = 0; prev_stall = 0; prev_dat = 0;
        while (recv < 1000 && cyc < 20000) begin
            if (!a_in_valid && sent < 1000 && $urandom_range(0, 1) == 1) begin
                a_in_valid = 1;
                a_in_data  = 8'($urandom_range(0, 255));
            end
            a_out_ready = 1'($urandom_range(0, 1));
            mid();
            chk("rnd_occ", a_occ, sb.size());
            if (prev_stall) begin
                chk("rnd_hold_vld", a_out_valid, 1);
                chk("rnd_hold_dat", a_out_data, prev_dat);
            end
            prev_stall = a_out_valid && !a_out_ready;
            prev_dat   = a_out_data;
            pop  = a_out_valid && a_out_ready;
            push = a_in_valid && a_in_ready;
            if (pop) begin
                chk("rnd_nonempty", sb.size() > 0, 1);
                if (sb.size() > 0) chk("rnd_dat", a_out_data, sb.pop_front());
                recv++;
            end
            if (push) begin
                sb.push_back(a_in_data);
                sent++;
            end
            tick();
            cyc++;
            if (push) a_in_valid = 0;
        end
        chk("rnd_recv", recv, 1000);
        a_in_valid = 0; a_out_ready = 0;

        // STAGES=1: continuous input, consumer ready every other cycle.
        b_in_valid = 1; b_in_data = 8'h00; recv_win = 0;
        prev_occ = 0; prev_rdy = 1; prev_pop = 0;
        for (int i = 0; i < 40; i++) begin
            b_out_ready = 1'(i % 2);
            mid();
            chk("s1_occ", b_occ, sb2.size());
            if (i >= 3) begin
                chk("s1_occ_toggle", b_occ != prev_occ, 1);
                chk("s1_occ_range", (b_occ >= 1 && b_occ <= 2), 1);
            end
            if (i >= 1 && !prev_rdy && prev_pop) chk("s1_ready_after_pop", b_in_ready, 1);
            pop  = b_out_valid && b_out_ready;
            push = b_in_valid && b_in_ready;
            if (pop) begin
                chk("s1_nonempty", sb2.size() > 0, 1);
                if (sb2.size() > 0) chk("s1_dat", b_out_data, sb2.pop_front());
                if (i >= 10) recv_win++;
            end
            prev_occ = b_occ;
            prev_rdy = b_in_ready;
            prev_pop = pop;
            if (push) sb2.push_back(b_in_data);
            tick();
            if (push) b_in_data = b_in_data + 8'd1;
        end
        chk("s1_throughput", recv_win, 15);
        b_in_valid = 0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
